// File: rtl/aes_reset_sequencer.sv
// Reset release sequencer for the AES datapath: stretches reset, releases key expansion,
// waits for key_ready, then releases the round core. Optional heartbeat: RSTSEQ_HEARTBEAT_EN.
module aes_reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int KEY_TIMEOUT = 1024,
    parameter int CNT_W       = 12
`ifdef RSTSEQ_HEARTBEAT_EN
    ,
    parameter int HB_DIV      = 50
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_ready,
    input  logic       soft_rst_req,
    output logic       key_rst_n,
    output logic       core_rst_n,
    output logic       sys_ready,
    output logic       fault,
    output logic [2:0] seq_state
`ifdef RSTSEQ_HEARTBEAT_EN
    ,
    output logic       heartbeat
`endif
);

    localparam logic [2:0] HOLD     = 3'd0;
    localparam logic [2:0] KEY_REL  = 3'd1;
    localparam logic [2:0] CORE_REL = 3'd2;
    localparam logic [2:0] RUN      = 3'd3;
    localparam logic [2:0] FAULT    = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_TIMEOUT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;

    assign seq_state = state;

    // Hard reset beats soft request; soft request beats normal sequencing.
    // The counter is cleared on every transition so it can never wrap.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= HOLD;
            cnt        <= CNT_ZERO;
            key_rst_n  <= 1'b0;
            core_rst_n <= 1'b0;
            sys_ready  <= 1'b0;
            fault      <= 1'b0;
        end else if (soft_rst_req) begin
            state      <= HOLD;
            cnt        <= CNT_ZERO;
            key_rst_n  <= 1'b0;
            core_rst_n <= 1'b0;
            sys_ready  <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state     <= KEY_REL;
                        cnt       <= CNT_ZERO;
                        key_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                KEY_REL: begin
                    if (key_ready) begin
                        state      <= CORE_REL;
                        cnt        <= CNT_ZERO;
                        core_rst_n <= 1'b1;
                    end else if (cnt == KEY_LAST) begin
                        state     <= FAULT;
                        cnt       <= CNT_ZERO;
                        fault     <= 1'b1;
                        key_rst_n <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                CORE_REL: begin
                    state     <= RUN;
                    cnt       <= CNT_ZERO;
                    sys_ready <= 1'b1;
                end
                RUN: begin
                    if (!key_ready) begin
                        state      <= FAULT;
                        cnt        <= CNT_ZERO;
                        fault      <= 1'b1;
                        sys_ready  <= 1'b0;
                        core_rst_n <= 1'b0;
                        key_rst_n  <= 1'b0;
                    end
                end
                FAULT: begin
                    cnt        <= CNT_ZERO;
                    key_rst_n  <= 1'b0;
                    core_rst_n <= 1'b0;
                    sys_ready  <= 1'b0;
                    fault      <= 1'b1;
                end
                default: begin
                    state      <= HOLD;
                    cnt        <= CNT_ZERO;
                    key_rst_n  <= 1'b0;
                    core_rst_n <= 1'b0;
                    sys_ready  <= 1'b0;
                    fault      <= 1'b0;
                end
            endcase
        end
    end

`ifdef RSTSEQ_HEARTBEAT_EN
    localparam int HB_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam logic [HB_W-1:0] HB_ZERO = '0;
    localparam logic [HB_W-1:0] HB_ONE  = HB_W'(1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_DIV - 1);

    logic [HB_W-1:0] hb_cnt;

    // Heartbeat keys off the registered state, so it drops the edge after RUN is left.
    always_ff @(posedge clock) begin
        if (!reset || soft_rst_req || state != RUN) begin
            hb_cnt    <= HB_ZERO;
            heartbeat <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt    <= HB_ZERO;
            heartbeat <= ~heartbeat;
        end else begin
            hb_cnt <= hb_cnt + HB_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_aes_reset_sequencer.sv
// Scoreboard bench for aes_reset_sequencer: stimulus queues timestamped expected output
// vectors, a monitor pops them at their cycle and flags any unexpected output change.
module tb_aes_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       key_ready;
    logic       soft_rst_req;
    logic       key_rst_n;
    logic       core_rst_n;
    logic       sys_ready;
    logic       fault;
    logic [2:0] seq_state;

    aes_reset_sequencer #(
        .HOLD_CYCLES(16),
        .KEY_TIMEOUT(8),
        .CNT_W(12)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key_ready(key_ready),
        .soft_rst_req(soft_rst_req),
        .key_rst_n(key_rst_n),
        .core_rst_n(core_rst_n),
        .sys_ready(sys_ready),
        .fault(fault),
        .seq_state(seq_state)
    );

    // {key_rst_n, core_rst_n, sys_ready, fault, seq_state}
    localparam logic [6:0] V_ZERO  = 7'b0000_000;
    localparam logic [6:0] V_KEY   = 7'b1000_001;
    localparam logic [6:0] V_CORE  = 7'b1100_010;
    localparam logic [6:0] V_RUN   = 7'b1110_011;
    localparam logic [6:0] V_FAULT = 7'b0001_100;

    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;
    bit         mon_en = 0;
    int         q_cyc[$];
    logic [6:0] q_vec[$];
    string      q_name[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic push_exp(input int c, input logic [6:0] v, input string n);
        q_cyc.push_back(c);
        q_vec.push_back(v);
        q_name.push_back(n);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    // r is the cycle count at the negedge before the first free HOLD edge
    task automatic applyStimulus_release(input int r, input string tag);
        push_exp(r + 16, V_KEY,  {tag, "_key_rel"});
        push_exp(r + 17, V_CORE, {tag, "_core_rel"});
        push_exp(r + 18, V_RUN,  {tag, "_run"});
    endtask

    task automatic soft_pulse(input string tag);
        int s;
        s = cyc;
        soft_rst_req = 1'b1;
        push_exp(s + 1, V_ZERO, tag);
        @(negedge clock);
        soft_rst_req = 1'b0;
    endtask

    // Monitor: compares at each expected cycle, otherwise outputs must hold steady.
    initial begin : monitor
        logic [6:0] cur;
        logic [6:0] prev;
        bit         have_prev;
        have_prev = 0;
        prev = '0;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                cur = {key_rst_n, core_rst_n, sys_ready, fault, seq_state};
                if (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
                    checks++;
                    if (cur !== q_vec[0]) begin
                        fails++;
                        $display("[TB] FAIL %s cyc=%0d got=%b exp=%b", q_name[0], cyc, cur, q_vec[0]);
                    end
                    void'(q_cyc.pop_front());
                    void'(q_vec.pop_front());
                    void'(q_name.pop_front());
                end else if (q_cyc.size() > 0 && q_cyc[0] < cyc) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL %s missed cyc=%0d exp_cyc=%0d", q_name[0], cyc, q_cyc[0]);
                    void'(q_cyc.pop_front());
                    void'(q_vec.pop_front());
                    void'(q_name.pop_front());
                end else if (have_prev && cur !== prev) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_change cyc=%0d got=%b exp=%b", cyc, cur, prev);
                end
                prev = cur;
                have_prev = 1;
            end
        end
    end

    initial begin : stimulus
        int r;
        int r2;
        int c;
        int n;
        reset = 1'b0;
        key_ready = 1'b0;
        soft_rst_req = 1'b0;
        wait_until(3);

        $display("[TB] reset state");
        push_exp(cyc + 1, V_ZERO, "reset_state");
        mon_en = 1;
        @(negedge clock);

        $display("[TB] case 1: release with key_ready tied high");
        r = cyc;
        reset = 1'b1;
        key_ready = 1'b1;
        applyStimulus_release(r, "case1");
        wait_until(r + 22);

        $display("[TB] case 3: key_ready drop in RUN");
        c = cyc;
        key_ready = 1'b0;
        push_exp(c + 1, V_FAULT, "run_drop_fault");
        @(negedge clock);
        key_ready = 1'b1;
        wait_until(c + 12);

        $display("[TB] case 4: soft reset out of FAULT");
        soft_pulse("soft_from_fault");
        r = cyc;
        applyStimulus_release(r, "case4");
        wait_until(r + 22);

        $display("[TB] case 2: key_ready timeout");
        soft_pulse("soft_from_run");
        key_ready = 1'b0;
        r = cyc;
        push_exp(r + 16, V_KEY,   "case2_key_rel");
        push_exp(r + 24, V_FAULT, "timeout_fault");
        push_exp(r + 124, V_FAULT, "fault_sticky");
        wait_until(r + 126);

        $display("[TB] key_ready on the timeout cycle wins");
        soft_pulse("soft_before_prio");
        r = cyc;
        push_exp(r + 16, V_KEY, "prio_key_rel");
        wait_until(r + 23);
        key_ready = 1'b1;
        push_exp(r + 24, V_CORE, "prio_core_rel");
        push_exp(r + 25, V_RUN,  "prio_run");
        wait_until(r + 30);

        $display("[TB] case 5: reset in KEY_REL at cnt=5");
        soft_pulse("soft_before_midreset");
        key_ready = 1'b0;
        r = cyc;
        push_exp(r + 16, V_KEY, "case5_key_rel");
        wait_until(r + 21);
        reset = 1'b0;
        push_exp(r + 22, V_ZERO, "mid_reset");
        @(negedge clock);
        reset = 1'b1;
        key_ready = 1'b1;
        r2 = cyc;
        applyStimulus_release(r2, "case5");
        wait_until(r2 + 22);

        n = 0;
        while (q_cyc.size() > 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        while (q_cyc.size() > 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s undelivered exp_cyc=%0d", q_name[0], q_cyc[0]);
            void'(q_cyc.pop_front());
            void'(q_vec.pop_front());
            void'(q_name.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
